// File: rtl/spi_regfile_ctrl.sv
// SPI mode-0 slave register file, oversampled in the clk domain: NUM_REGS r/w config words plus NUM_STATUS read-only status words.
// Latency: SYNC_STAGES clks to detect an SCLK edge; a write commits the clk after the final bit's rising edge; a read word loads one clk after the command/word boundary.
// Backpressure: none; the SPI master owns the bus timing, and clk must run at least 4x SCLK.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   spi_sclk/mosi/cs_n  raw SPI inputs (synchronised internally)
//   spi_miso/_oe        serial read data and its output enable (tri-state built above)
//   cfg_regs            flat config image, register k at [k*DATA_WIDTH +: DATA_WIDTH]
//   cfg_wr_strobe       one-clk pulse per register when it is written
//   status_in           flat status words, snapshotted when a read word is loaded
//   frame_err           one-clk pulse when CS_n rises part-way through a byte/word
module spi_regfile_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int NUM_STATUS  = 4,
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             spi_sclk,
  input  logic                             spi_mosi,
  input  logic                             spi_cs_n,
  output logic                             spi_miso,
  output logic                             spi_miso_oe,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   cfg_regs,
  output logic [NUM_REGS-1:0]              cfg_wr_strobe,
  input  logic [NUM_STATUS*DATA_WIDTH-1:0] status_in,
  output logic                             frame_err
);

  localparam int BCW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q,   cs_prev_d;
  state_t                 state_q,     state_d;
  logic [BCW-1:0]         bit_cnt_q,   bit_cnt_d;
  logic [DATA_WIDTH-1:0]  rx_q,        rx_d;
  logic [DATA_WIDTH-1:0]  tx_q,        tx_d;
  logic [ADDR_WIDTH-1:0]  addr_q,      addr_d;
  logic                   rw_q,        rw_d;
  logic                   load_pend_q, load_pend_d;
  logic                   oe_q,        oe_d;
  logic                   frame_err_q, frame_err_d;
  logic [NUM_REGS-1:0]    strobe_q,    strobe_d;
  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];

  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [DATA_WIDTH-1:0]  rx_next;
  logic [DATA_WIDTH-1:0]  rd_word;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // CS_n history resets low so a frame that is in flight across reset is
  // ignored until the master releases and re-asserts chip select.
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign rx_next   = {rx_q[DATA_WIDTH-2:0], mosi_s};

  // Read mux: config, then status, then zero for anything unmapped.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr_q == ADDR_WIDTH'(k)) rd_word = regs_q[k];
    end
    for (int j = 0; j < NUM_STATUS; j++) begin
      if (addr_q == ADDR_WIDTH'(NUM_REGS + j)) rd_word = status_in[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    load_pend_d = 1'b0;
    oe_d        = oe_q;
    frame_err_d = 1'b0;
    strobe_d    = '0;
    regs_d      = regs_q;

    // Deferred one clk after the boundary so addr_q already holds the new address.
    if (load_pend_q) begin
      tx_d = rd_word;
      oe_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
        end
      end
      ST_CMD: begin
        if (sclk_rise) begin
          rx_d = rx_next;
          if (bit_cnt_q == BCW'(7)) begin
            rw_d        = rx_next[7];
            addr_d      = rx_next[ADDR_WIDTH-1:0];
            load_pend_d = rx_next[7];
            bit_cnt_d   = '0;
            state_d     = ST_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      ST_DATA: begin
        if (sclk_rise) begin
          rx_d = rx_next;
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            if (!rw_q) begin
              // Status/unmapped addresses match no register: word dropped, no strobe.
              for (int k = 0; k < NUM_REGS; k++) begin
                if (addr_q == ADDR_WIDTH'(k)) begin
                  regs_d[k]   = rx_next;
                  strobe_d[k] = 1'b1;
                end
              end
            end
            load_pend_d = rw_q;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
        // The fall that follows a word's last bit must not shift: the freshly
        // loaded MSB has to stay on MISO for the next word's first rising edge.
        if (sclk_fall && rw_q && bit_cnt_q != '0) begin
          tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A commit in the same clk as CS_n rising has already completed above and
    // left bit_cnt_d at zero, so it is not reported as an abort.
    if (state_q != ST_IDLE && cs_rise) begin
      frame_err_d = (bit_cnt_d != '0);
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      oe_d        = 1'b0;
      load_pend_d = 1'b0;
      tx_d        = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      load_pend_q <= 1'b0;
      oe_q        <= 1'b0;
      frame_err_q <= 1'b0;
      strobe_q    <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VALUES[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      load_pend_q <= load_pend_d;
      oe_q        <= oe_d;
      frame_err_q <= frame_err_d;
      strobe_q    <= strobe_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign spi_miso      = tx_q[DATA_WIDTH-1];
  assign spi_miso_oe   = oe_q;
  assign cfg_wr_strobe = strobe_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_ctrl.sv
// Bench for spi_regfile_ctrl: a bit-banged SPI master plus a frame-level model of the register file.
// The model tracks register contents, expected strobes/errors and expected MISO words per frame.
// A single compare process owns every check; the driver posts one-off checks to it through a queue.
module tb_spi_regfile_ctrl;

  localparam int DW     = 32;
  localparam int NR     = 16;
  localparam int NS     = 4;
  localparam int H      = 4;   // clks per SCLK half period
  localparam int SETTLE = 14;  // clks after a model change before outputs must match it
  localparam logic [NR*DW-1:0] RV = {{((NR-2)*DW){1'b0}}, 32'h0000_0080, 32'h0000_0000};

  logic              clk = 1'b0;
  logic              rst;
  logic              spi_sclk, spi_mosi, spi_cs_n;
  logic              spi_miso, spi_miso_oe, frame_err;
  logic [NR*DW-1:0]  cfg_regs;
  logic [NR-1:0]     cfg_wr_strobe;
  logic [NS*DW-1:0]  status_in;

  always #5 clk = ~clk;

  spi_regfile_ctrl #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_STATUS(NS), .ADDR_WIDTH(7),
    .SYNC_STAGES(2), .RESET_VALUES(RV)
  ) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .cfg_regs(cfg_regs),
    .cfg_wr_strobe(cfg_wr_strobe), .status_in(status_in), .frame_err(frame_err)
  );

  typedef struct {
    string       nm;
    logic [31:0] got;
    logic [31:0] exp;
  } req_t;

  req_t reqq[$];

  // Model state, written only by the driver.
  logic [31:0] exp_regs [NR];
  int          exp_strb [NR];
  logic        exp_oe;
  int          exp_err;
  int          stamp;
  logic        done;
  logic [31:0] tx_words [4];
  logic [31:0] rx_words [4];
  logic        mid_stat_en;
  logic [31:0] mid_stat_val;

  // Observation state, written only by the compare process.
  int          cyc;
  int          total, bad;
  int          seen_strb [NR];
  int          seen_err;
  logic [NR-1:0] prev_strb;
  logic        prev_err;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s got=%h want=%h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic void push(input string nm, input logic [31:0] got, input logic [31:0] exp);
    req_t r;
    r.nm = nm; r.got = got; r.exp = exp;
    reqq.push_back(r);
  endfunction

  // Compare process: posted checks, pulse-width rules and the settled image/oe.
  initial begin
    req_t r;
    total = 0; bad = 0; cyc = 0; seen_err = 0; prev_strb = '0; prev_err = 1'b0;
    for (int k = 0; k < NR; k++) seen_strb[k] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      while (reqq.size() != 0) begin
        r = reqq.pop_front();
        chk(r.nm, r.got, r.exp);
      end
      for (int k = 0; k < NR; k++) begin
        if (cfg_wr_strobe[k] === 1'b1) seen_strb[k]++;
        chk($sformatf("strobe_width%0d", k), {31'b0, prev_strb[k] & cfg_wr_strobe[k]}, 32'h0);
      end
      if (frame_err === 1'b1) seen_err++;
      chk("frame_err_width", {31'b0, prev_err & frame_err}, 32'h0);
      prev_strb = cfg_wr_strobe;
      prev_err  = frame_err;
      if (cyc - stamp > SETTLE) begin
        for (int k = 0; k < NR; k++) chk($sformatf("cfg_reg%0d", k), cfg_regs[k*DW +: DW], exp_regs[k]);
        chk("miso_oe", {31'b0, spi_miso_oe}, {31'b0, exp_oe});
      end
      if (done && reqq.size() == 0) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      if (cyc > 60000) begin
        total++; bad++;
        $display("FAIL timeout cyc=%0d limit=60000", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    @(negedge clk);
    spi_mosi = b;
    tick(H);
    m = spi_miso;
    spi_sclk = 1'b1;
    tick(H);
    spi_sclk = 1'b0;
  endtask

  task automatic cs_fall();
    @(negedge clk);
    spi_cs_n = 1'b0;
    tick(6);
  endtask

  task automatic cs_rise();
    exp_oe = 1'b0;
    stamp  = cyc;
    @(negedge clk);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a < NR) return exp_regs[a];
    if (a < NR + NS) return status_in[(a-NR)*DW +: DW];
    return 32'h0;
  endfunction

  function automatic int sum_strb();
    int s = 0;
    for (int k = 0; k < NR; k++) s += seen_strb[k];
    return s;
  endfunction

  // One complete frame: command, nwords full words, then tail_bits of a partial word.
  task automatic frame(input logic [7:0] cmd, input int nwords, input int tail_bits);
    int a;
    logic rd, m;
    logic [31:0] w, r, e;
    a  = int'(cmd[6:0]);
    rd = cmd[7];
    cs_fall();
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && rd) begin exp_oe = 1'b1; stamp = cyc; end
      spi_bit(cmd[7-i], m);
    end
    for (int wi = 0; wi < nwords; wi++) begin
      w = tx_words[wi];
      e = model_read(a);
      r = '0;
      for (int b = 0; b < DW; b++) begin
        if (b == DW-1 && !rd) begin
          if (a < NR) begin exp_regs[a] = w; exp_strb[a]++; end
          stamp = cyc;
        end
        if (b == 10 && mid_stat_en) status_in[31:0] = mid_stat_val;
        spi_bit(w[DW-1-b], m);
        r = {r[30:0], m};
      end
      if (rd) begin
        rx_words[wi] = r;
        push($sformatf("rd_word_a%0d", a), r, e);
      end
      a = (a + 1) % 128;
    end
    if (tail_bits > 0) begin
      w = tx_words[nwords];
      for (int b = 0; b < tail_bits; b++) spi_bit(w[DW-1-b], m);
      exp_err++;
    end
    cs_rise();
  endtask

  initial begin
    int s14, s15, st;
    logic m;
    rst = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; status_in = '0;
    exp_oe = 1'b0; exp_err = 0; stamp = 0; done = 1'b0; mid_stat_en = 1'b0; mid_stat_val = '0;
    for (int k = 0; k < NR; k++) begin exp_regs[k] = RV[k*DW +: DW]; exp_strb[k] = 0; end
    for (int k = 0; k < 4; k++) begin tx_words[k] = '0; rx_words[k] = '0; end
    tick(4);
    push("rst_reg0", cfg_regs[31:0], 32'h0);
    push("rst_reg1", cfg_regs[63:32], 32'h0000_0080);
    push("rst_oe_miso", {30'b0, spi_miso_oe, spi_miso}, 32'h0);
    push("rst_strobe_err", {15'b0, frame_err, cfg_wr_strobe}, 32'h0);
    rst = 1'b0;
    tick(6);

    // Single write to reg0.
    tx_words[0] = 32'hDEAD_BEEF;
    frame(8'h00, 1, 0);
    push("t1_reg0", cfg_regs[31:0], 32'hDEAD_BEEF);
    push("t1_strb0", 32'(seen_strb[0]), 32'd1);

    // Burst write from reg14 running into the status range.
    s14 = seen_strb[14]; s15 = seen_strb[15]; st = sum_strb();
    tx_words[0] = 32'h1111_1111; tx_words[1] = 32'h2222_2222; tx_words[2] = 32'h3333_3333;
    frame(8'h0E, 3, 0);
    push("t2_reg14", cfg_regs[14*DW +: DW], 32'h1111_1111);
    push("t2_reg15", cfg_regs[15*DW +: DW], 32'h2222_2222);
    push("t2_strb14", 32'(seen_strb[14] - s14), 32'd1);
    push("t2_strb15", 32'(seen_strb[15] - s15), 32'd1);
    push("t2_strb_all", 32'(sum_strb() - st), 32'd2);

    // Status read; status changes mid-shift must not leak into the word.
    for (int k = 0; k < 4; k++) tx_words[k] = '0;
    status_in[31:0] = 32'h1234_5678;
    mid_stat_en = 1'b1; mid_stat_val = 32'hFFFF_0000;
    frame(8'h90, 1, 0);
    mid_stat_en = 1'b0;
    push("t3_status_rd", rx_words[0], 32'h1234_5678);

    // Config read-back with burst, and address wrap from 127 to 0.
    frame(8'h81, 2, 0);
    push("t4_rd_reg1", rx_words[0], 32'h0000_0080);
    push("t4_rd_reg2", rx_words[1], 32'h0000_0000);
    frame(8'hFF, 2, 0);
    push("t4_rd_a127", rx_words[0], 32'h0000_0000);
    push("t4_rd_wrap0", rx_words[1], 32'hDEAD_BEEF);

    // SCLK toggling with CS_n high is ignored.
    spi_mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(H); spi_sclk = 1'b1; tick(H); spi_sclk = 1'b0;
    end
    tick(6);
    push("idle_err", 32'(seen_err), 32'd0);

    // Abort after 12 data bits, then a complete write to the same register.
    tx_words[0] = 32'hA5A5_A5A5;
    frame(8'h03, 0, 12);
    push("t5_reg3_kept", cfg_regs[3*DW +: DW], 32'h0);
    push("t5_err", 32'(seen_err), 32'd1);
    push("t5_strb3", 32'(seen_strb[3]), 32'd0);
    tx_words[0] = 32'h0BAD_C0DE;
    frame(8'h03, 1, 0);
    push("t5_reg3_new", cfg_regs[3*DW +: DW], 32'h0BAD_C0DE);

    // Reset 20 bits into a write to reg0.
    cs_fall();
    for (int i = 0; i < 8; i++) spi_bit(1'b0, m);
    for (int i = 0; i < 20; i++) spi_bit(i[0], m);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NR; k++) exp_regs[k] = RV[k*DW +: DW];
    exp_oe = 1'b0;
    stamp = cyc;
    tick(3);
    push("t6_rst_reg0", cfg_regs[31:0], 32'h0);
    push("t6_rst_reg3", cfg_regs[3*DW +: DW], 32'h0);
    push("t6_rst_reg1", cfg_regs[63:32], 32'h0000_0080);
    push("t6_rst_outs", {28'b0, frame_err, spi_miso_oe, spi_miso, |cfg_wr_strobe}, 32'h0);
    rst = 1'b0;
    tick(5);
    cs_rise();
    push("t6_no_err", 32'(seen_err), 32'd1);
    tx_words[0] = 32'hCAFE_F00D;
    frame(8'h00, 1, 0);
    push("t6_reg0", cfg_regs[31:0], 32'hCAFE_F00D);

    tick(10);
    for (int k = 0; k < NR; k++) push($sformatf("strb_cnt%0d", k), 32'(seen_strb[k]), 32'(exp_strb[k]));
    push("err_cnt", 32'(seen_err), 32'(exp_err));
    tick(4);
    done = 1'b1;
  end

endmodule
